// File: rtl/jtopl_slot_regs.sv
// jtopl_slot_regs
// Per-slot parameter store and slot sequencer for the OPL2 envelope path.
// The CPU writes an index (addr=0) and then data (addr=1). Operator fields
// (20h/40h/60h/80h + offset) and channel fields (A0h..A8h, B0h..B8h) are
// stored. One slot per cenop is then replayed, aligned to the zero pulse,
// onto stage-I, stage-II and stage-IV buses for jtopl_eg.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   cenop         operator-rate clock enable
//   zero          slot-0 marker, only looked at when cenop=1
//   wr, addr, din CPU write strobe, port select (0 index / 1 data), data
//   *_I           stage-I fields for the slot currently shown
//   ksr_II        ksr of the slot shown one cenop earlier
//   amsen_IV, ksl_IV, tl_IV  fields of the slot shown three cenop earlier
module jtopl_slot_regs (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic       zero,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] din,
  output logic       en_sus_I,
  output logic [3:0] arate_I,
  output logic [3:0] drate_I,
  output logic [3:0] sl_I,
  output logic [3:0] rrate_I,
  output logic       keyon_I,
  output logic [9:0] fnum_I,
  output logic [2:0] block_I,
  output logic       ksr_II,
  output logic       amsen_IV,
  output logic [1:0] ksl_IV,
  output logic [5:0] tl_IV
);

  localparam int NUM_SLOTS = 18;
  localparam int NUM_CH    = 9;

  logic [7:0] idx_reg;

  // Reg 20h only contributes AM (bit7), EG-type (bit5) and KSR (bit4).
  logic [2:0] r20_mem [NUM_SLOTS];
  logic [7:0] r40_mem [NUM_SLOTS];
  logic [7:0] r60_mem [NUM_SLOTS];
  logic [7:0] r80_mem [NUM_SLOTS];
  logic [7:0] fnl_mem [NUM_CH];
  logic [5:0] b0_mem  [NUM_CH];

  logic [4:0] ptr_reg;
  logic [4:0] ptr_next;

  // Slot -> channel map: row = s/6, column = s%6, channel = 3*row + col%3.
  logic [3:0] ch_lut [NUM_SLOTS];
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_ch_lut
    assign ch_lut[gi] = 4'((gi / 6) * 3 + (gi % 6) % 3);
  end

  // Write address decode from the latched index.
  logic [1:0] wr_row;
  logic [2:0] wr_col;
  logic       op_ok;
  logic       ch_ok;
  logic [4:0] wr_slot;
  logic [3:0] wr_ch;

  assign wr_row  = idx_reg[4:3];
  assign wr_col  = idx_reg[2:0];
  assign op_ok   = (wr_row != 2'd3) && (wr_col < 3'd6);
  assign wr_slot = {3'b000, wr_row} * 5'd6 + {2'b00, wr_col};
  assign wr_ch   = idx_reg[3:0];
  assign ch_ok   = (wr_ch < 4'd9);

  logic we20, we40, we60, we80, we_a0, we_b0;
  assign we20  = (idx_reg[7:5] == 3'd1) && op_ok;
  assign we40  = (idx_reg[7:5] == 3'd2) && op_ok;
  assign we60  = (idx_reg[7:5] == 3'd3) && op_ok;
  assign we80  = (idx_reg[7:5] == 3'd4) && op_ok;
  assign we_a0 = (idx_reg[7:4] == 4'hA) && ch_ok;
  assign we_b0 = (idx_reg[7:4] == 4'hB) && ch_ok;

  // Register file: reset clears everything, writes land one clk after wr.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r20_mem[i] <= '0;
        r40_mem[i] <= '0;
        r60_mem[i] <= '0;
        r80_mem[i] <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        fnl_mem[i] <= '0;
        b0_mem[i]  <= '0;
      end
    end else if (wr) begin
      if (!addr) begin
        idx_reg <= din;
      end else begin
        if (we20)  r20_mem[wr_slot] <= {din[7], din[5], din[4]};
        if (we40)  r40_mem[wr_slot] <= din;
        if (we60)  r60_mem[wr_slot] <= din;
        if (we80)  r80_mem[wr_slot] <= din;
        if (we_a0) fnl_mem[wr_ch]   <= din;
        if (we_b0) b0_mem[wr_ch]    <= din[5:0];
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg + 5'd1;
    if (zero || ptr_reg == 5'd17) begin
      ptr_next = '0;
    end
  end

  logic [3:0] rd_ch;
  assign rd_ch = ch_lut[ptr_next];

  // Stage pipeline for the delayed buses: {amsen, ksl, tl}.
  logic       ksr_s1_reg;
  logic [8:0] iv_s1_reg;
  logic [8:0] iv_s2_reg;
  logic [8:0] iv_s3_reg;

  // Readout uses the pre-edge memory contents, so a write on the same clk
  // as a slot's readout only becomes visible on its next visit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg    <= '0;
      en_sus_I   <= 1'b0;
      arate_I    <= '0;
      drate_I    <= '0;
      sl_I       <= '0;
      rrate_I    <= '0;
      keyon_I    <= 1'b0;
      fnum_I     <= '0;
      block_I    <= '0;
      ksr_s1_reg <= 1'b0;
      ksr_II     <= 1'b0;
      iv_s1_reg  <= '0;
      iv_s2_reg  <= '0;
      iv_s3_reg  <= '0;
      amsen_IV   <= 1'b0;
      ksl_IV     <= '0;
      tl_IV      <= '0;
    end else if (cenop) begin
      ptr_reg    <= ptr_next;
      en_sus_I   <= r20_mem[ptr_next][1];
      arate_I    <= r60_mem[ptr_next][7:4];
      drate_I    <= r60_mem[ptr_next][3:0];
      sl_I       <= r80_mem[ptr_next][7:4];
      rrate_I    <= r80_mem[ptr_next][3:0];
      keyon_I    <= b0_mem[rd_ch][5];
      block_I    <= b0_mem[rd_ch][4:2];
      fnum_I     <= {b0_mem[rd_ch][1:0], fnl_mem[rd_ch]};
      ksr_s1_reg <= r20_mem[ptr_next][0];
      ksr_II     <= ksr_s1_reg;
      iv_s1_reg  <= {r20_mem[ptr_next][2], r40_mem[ptr_next]};
      iv_s2_reg  <= iv_s1_reg;
      iv_s3_reg  <= iv_s2_reg;
      amsen_IV   <= iv_s3_reg[8];
      ksl_IV     <= iv_s3_reg[7:6];
      tl_IV      <= iv_s3_reg[5:0];
    end
  end

endmodule

// File: tb/tb_jtopl_slot_regs.sv
// Randomised scoreboard bench for jtopl_slot_regs. The driver keeps a plain
// model of the OPL register space (a 256-byte array) and the slot pointer;
// every cenop or reset cycle pushes the expected output set into a queue,
// and a monitor pops and compares after each such clock edge.
module tb_jtopl_slot_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cenop = 1'b0;
  logic       zero = 1'b0;
  logic       wr = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       en_sus_I, keyon_I, ksr_II, amsen_IV;
  logic [3:0] arate_I, drate_I, sl_I, rrate_I;
  logic [9:0] fnum_I;
  logic [2:0] block_I;
  logic [1:0] ksl_IV;
  logic [5:0] tl_IV;

  jtopl_slot_regs dut (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .wr(wr), .addr(addr),
    .din(din), .en_sus_I(en_sus_I), .arate_I(arate_I), .drate_I(drate_I),
    .sl_I(sl_I), .rrate_I(rrate_I), .keyon_I(keyon_I), .fnum_I(fnum_I),
    .block_I(block_I), .ksr_II(ksr_II), .amsen_IV(amsen_IV),
    .ksl_IV(ksl_IV), .tl_IV(tl_IV)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en_sus;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] sl;
    logic [3:0] rr;
    logic       keyon;
    logic [9:0] fnum;
    logic [2:0] block;
    logic       ksr;
    logic       amsen;
    logic [1:0] ksl;
    logic [5:0] tl;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       hist[$];
  logic [7:0] mem [256];
  logic [7:0] idx_m;
  int         ptr_m;
  int         n_vec = 0;
  int         n_err = 0;

  // Everything the envelope generator would see for slot s, read straight
  // from the register space.
  function automatic obs_t slot_view(input int s);
    obs_t v;
    int o, ch;
    logic [7:0] r20, r40, r60, r80, ra0, rb0;
    o   = (s / 6) * 8 + (s % 6);
    ch  = 3 * (o / 8) + (o % 8) % 3;
    r20 = mem[8'(32 + o)];
    r40 = mem[8'(64 + o)];
    r60 = mem[8'(96 + o)];
    r80 = mem[8'(128 + o)];
    ra0 = mem[8'(160 + ch)];
    rb0 = mem[8'(176 + ch)];
    v.en_sus = r20[5];
    v.ksr    = r20[4];
    v.amsen  = r20[7];
    v.ksl    = r40[7:6];
    v.tl     = r40[5:0];
    v.ar     = r60[7:4];
    v.dr     = r60[3:0];
    v.sl     = r80[7:4];
    v.rr     = r80[3:0];
    v.keyon  = rb0[5];
    v.block  = rb0[4:2];
    v.fnum   = {rb0[1:0], ra0};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    idx_m = 8'h00;
    ptr_m = 0;
    hist  = {};
    repeat (3) hist.push_front('0);
  endtask

  // One clock of stimulus, applied at the falling edge.
  task automatic step(input bit c, input bit z, input bit w, input bit a,
                      input logic [7:0] d, input bit r);
    obs_t cur, e;
    @(negedge clk);
    cenop = c; zero = z; wr = w; addr = a; din = d; rst = r;
    if (r) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      if (c) begin
        ptr_m = z ? 0 : (ptr_m + 1) % 18;
        cur = slot_view(ptr_m);
        hist.push_front(cur);
        e       = cur;
        e.ksr   = hist[1].ksr;
        e.amsen = hist[3].amsen;
        e.ksl   = hist[3].ksl;
        e.tl    = hist[3].tl;
        void'(hist.pop_back());
        exp_q.push_back(e);
      end
      // The write lands after this cycle's readout.
      if (w) begin
        if (!a) idx_m = d;
        else    mem[idx_m] = d;
      end
    end
  endtask

  task automatic tick(input bit w, input bit a, input logic [7:0] d);
    bit c, z;
    c = 1'($urandom % 2);
    if (c) z = (ptr_m == 17) || ($urandom % 60 == 0);
    else   z = 1'($urandom % 2);
    step(c, z, w, a, d, 1'b0);
  endtask

  task automatic wreg(input logic [7:0] idx, input logic [7:0] data);
    tick(1'b1, 1'b0, idx);
    tick(1'b1, 1'b1, data);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: after any clk edge that saw cenop or rst, compare outputs.
  initial begin
    obs_t e, act;
    bool_loop: forever begin
      @(posedge clk);
      if (rst || cenop) begin
        @(negedge clk);
        act = {en_sus_I, arate_I, drate_I, sl_I, rrate_I, keyon_I, fnum_I,
               block_I, ksr_II, amsen_IV, ksl_IV, tl_IV};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty vec %0d got %h required <none>", n_vec, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL outputs vec %0d got %h required %h", n_vec, act, e);
          end else begin
            $display("vec %0d ok %h", n_vec, act);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] ridx;
    int k;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Free run after reset, zero every 18th cenop.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, ptr_m == 17, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'($urandom % 2), 1'b0, 1'b0, 8'h00, 1'b0);
    end

    wreg(8'h63, 8'hA5); run(60);
    wreg(8'hA4, 8'h34); wreg(8'hB4, 8'h2D); run(60);
    wreg(8'h43, 8'hC5); wreg(8'h23, 8'h10); run(60);
    wreg(8'h66, 8'hFF); wreg(8'hA9, 8'hFF); run(60);

    // Write slot 0's 60h register on the same clk as its readout.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h60, 1'b0);
    while (ptr_m != 17) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, ptr_m == 17, 1'b0, 1'b0, 8'h00, 1'b0);

    // Mid-frame reset together with a data write and a cenop.
    run(7);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
    run(50);

    // Randomised register traffic.
    for (int n = 0; n < 250; n++) begin
      k = int'($urandom % 8);
      if (k < 5)       ridx = {3'($urandom_range(1, 4)), 5'($urandom)};
      else if (k == 5) ridx = {4'hA, 4'($urandom)};
      else if (k == 6) ridx = {4'hB, 4'($urandom)};
      else             ridx = 8'($urandom);
      wreg(ridx, 8'($urandom));
      run(int'($urandom % 6));
      if ($urandom % 120 == 0) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
